enable_sequencer: RTL and testbench
===================================

# enable_sequencer

Upstream stage of the dual-counter core: generates the single-cycle `enable` strobe that advances both core counters. It divides `clk` by a programmable ratio, runs continuously or for a fixed number of strobes, and reports activity and completion to the controller. It sits between the user-area control interface and the core's `enable` input, sharing the core's `clk`.

## Interface
- `DIV_W`, 8: width of prescale ratio `div`
- `BURST_W`, 8: width of burst length `burst_len`
- `vccd1` / `vssd1` inout, 1, 1.8 V supply / ground; present only under `USE_POWER_PINS`
- `clk` input 1: single clock, shared with core
- `reset_n` input 1: asynchronous, active-low reset
- `start` input 1: level sampled each edge; starts a run from IDLE
- `stop` input 1: level sampled each edge; aborts a run
- `div` input DIV_W: strobe period minus one; latched at start
- `mode_burst` input 1: 1 = burst run, 0 = continuous; latched at start (`BURST_EN` only)
- `burst_len` input BURST_W: strobes per burst; latched at start (`BURST_EN` only)
- `enable` output 1: registered single-cycle strobe to core `enable`
- `busy` output 1: registered, high while state ≠ IDLE
- `done` output 1: registered one-cycle pulse at burst completion

## Operation
- States: IDLE, RUN, DONE. Registers: state, `cnt` (DIV_W), `div_q`, `pulses` (BURST_W), `len_q`, `burst_q`.
- IDLE: `enable`=0. If `start`=1 and `stop`=0, latch `div`/`mode_burst`/`burst_len`, clear `cnt` and `pulses`, go to RUN. `start` with `stop` in the same cycle: stay IDLE.
- Burst with `len`=0 at start: go directly to DONE; no strobe issued.
- RUN: each edge, if `cnt`==`div_q`, then `cnt`←0 and `enable`←1; else `cnt`←`cnt`+1 and `enable`←0. No overflow: `cnt` never exceeds `div_q`.
- RUN, burst: each strobe increments `pulses`. At the edge issuing strobe number `len_q`, go to DONE.
- RUN: `stop`=1 has priority over strobe generation. Go to IDLE, `enable`←0, no `done`. `start` in RUN is ignored. `div` changes in RUN are ignored.
- DONE: `done`=1 for exactly this cycle, `enable`=0. Unconditionally go to IDLE. `start` and `stop` are ignored.
- Reset (any time, including mid-run): state=IDLE, `cnt`=0, `pulses`=0. `enable`=0, `busy`=0, `done`=0. Latched fields=0.

## Timing
- `start` sampled at edge E0 → `busy`=1 from E0.
- First `enable` is high in the cycle after edge E(div+1). Subsequent strobes occur every `div`+1 cycles.
- `div`=0: `enable` is high every cycle from E1 onward.
- Burst: `done` is high in the cycle immediately after the last strobe cycle. `busy` falls one edge later.
- `stop` sampled at edge Es → `busy`=0 and `enable`=0 from Es.
- Minimum IDLE→RUN restart: a `start` one cycle after `done` is accepted.

## Configuration
- `ENABLE_SEQ_BURST_EN` defined: `mode_burst`/`burst_len` ports, the `pulses` counter and the DONE state exist, with behaviour as above.
- `ENABLE_SEQ_BURST_EN` not defined: those ports and that logic are absent. Runs are always continuous until `stop`. `done` is tied to 0 and DONE is unreachable.

## Structure
- Shared package `enable_seq_pkg`: state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and default widths `DIV_W_DEF`=8, `BURST_W_DEF`=8.
- One sub-module, `tick_prescaler`: holds `cnt`/`div_q`, with `clear` and `run` inputs and a `tick` output. The sequencer FSM owns the state, `pulses` and outputs.
- Instanced next to the two core counters in the top level, with `enable` wired to the core `enable`.

## Test plan
- Reset: assert `reset_n`=0 mid-run with `div`=3 → `enable`, `busy`, `done` are 0 asynchronously; after release, IDLE with no strobe until `start`.
- Continuous: `div`=3, pulse `start` → `enable` high for one cycle at cycles 4, 8, 12… after E0; `busy`=1 throughout; `done` never asserts.
- `div`=0: `start` → `enable` high every cycle from E1. `stop` at E10 → `enable`=0 and `busy`=0 from E10. Exactly 9 strobes observed.
- Burst (`ENABLE_SEQ_BURST_EN`): `div`=1, `burst_len`=5 → 5 strobes 2 cycles apart; `done` is a one-cycle pulse right after the 5th strobe; `busy` falls next edge; core `out1` advances by 5.
- Boundary: `burst_len`=0 → `done` pulse at E1 with no strobe. Simultaneous `start`+`stop` in IDLE → stays IDLE. `stop` during burst → no `done`.
- Restart: `start` held high through `done` → new run accepted the cycle after `done`. The latched `div`/`burst_len` come from the new sample.

Source files
------------

// File: rtl/enable_seq_pkg.sv
// enable_seq_pkg: shared definitions for the enable sequencer.
//   seq_state_t  : sequencer state encoding (IDLE/RUN/DONE)
//   DIV_W_DEF    : default width of the prescale ratio
//   BURST_W_DEF  : default width of the burst length
package enable_seq_pkg;

  localparam int unsigned DIV_W_DEF   = 8;
  localparam int unsigned BURST_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_t;

endpackage

// File: rtl/enable_sequencer_tick_prescaler.sv
// tick_prescaler: divides clk by (div_q + 1) while the sequencer is running.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   clear        : run accepted this edge; latch div and restart the count
//   run          : count enable (sequencer in RUN and not stopping)
//   div          : strobe period minus one, sampled on clear
//   tick         : combinational, high when this edge completes a period
module tick_prescaler
  import enable_seq_pkg::*;
#(
  parameter int unsigned DIV_W = DIV_W_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             run,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] div_q;

  // Wrap at div_q so cnt never exceeds the latched ratio.
  assign tick = run && (cnt == div_q);

  // Ratio latch and period counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt   <= '0;
      div_q <= '0;
    end else if (clear) begin
      cnt   <= '0;
      div_q <= div;
    end else if (run) begin
      if (cnt == div_q) cnt <= '0;
      else              cnt <= cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/enable_sequencer.sv
// enable_sequencer: generates the single-cycle enable strobe for the
// dual-counter core, dividing clk by (div + 1), continuously or for a burst.
// Ports:
//   vccd1, vssd1    : supply pins, only when USE_POWER_PINS is defined
//   clk, reset_n    : clock, asynchronous active-low reset
//   start, stop     : run control levels, sampled every edge
//   div             : strobe period minus one, latched at start
//   mode_burst      : 1 = burst run (ENABLE_SEQ_BURST_EN only)
//   burst_len       : strobes per burst (ENABLE_SEQ_BURST_EN only)
//   enable          : registered one-cycle strobe to the core
//   busy            : registered, high while a run (including its done pulse) is active
//   done            : registered one-cycle pulse after the last burst strobe
// Macro ENABLE_SEQ_BURST_EN adds the burst feature; without it runs are
// continuous until stop and done is tied low.
module enable_sequencer
  import enable_seq_pkg::*;
#(
  parameter int unsigned DIV_W   = DIV_W_DEF,
  parameter int unsigned BURST_W = BURST_W_DEF
) (
`ifdef USE_POWER_PINS
  inout  wire               vccd1,
  inout  wire               vssd1,
`endif
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              stop,
  input  logic [DIV_W-1:0]  div,
`ifdef ENABLE_SEQ_BURST_EN
  input  logic              mode_burst,
  input  logic [BURST_W-1:0] burst_len,
`endif
  output logic              enable,
  output logic              busy,
  output logic              done
);

  seq_state_t state;
  logic       accept_c;
  logic       run_c;
  logic       tick;

`ifdef USE_POWER_PINS
  logic unused_pwr;
  assign unused_pwr = vccd1 ^ vssd1;
`endif

  // stop wins over start in IDLE and over strobe generation in RUN.
  assign accept_c = (state == IDLE) && start && !stop;
  assign run_c    = (state == RUN) && !stop;

  tick_prescaler #(
    .DIV_W (DIV_W)
  ) u_prescaler (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (accept_c),
    .run     (run_c),
    .div     (div),
    .tick    (tick)
  );

`ifdef ENABLE_SEQ_BURST_EN
  logic [BURST_W-1:0] pulses;
  logic [BURST_W-1:0] len_q;
  logic               burst_q;
  logic [BURST_W-1:0] pulses_inc_c;

  assign pulses_inc_c = pulses + BURST_W'(1);
`else
  logic [BURST_W-1:0] unused_burst_w;
  assign unused_burst_w = '0;
  assign done = 1'b0;
`endif

  // Sequencer FSM; busy also covers the done cycle so it falls one edge later.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      enable <= 1'b0;
      busy   <= 1'b0;
`ifdef ENABLE_SEQ_BURST_EN
      done    <= 1'b0;
      pulses  <= '0;
      len_q   <= '0;
      burst_q <= 1'b0;
`endif
    end else begin
      enable <= 1'b0;
`ifdef ENABLE_SEQ_BURST_EN
      done   <= 1'b0;
`endif
      case (state)
        IDLE: begin
          busy <= 1'b0;
          if (accept_c) begin
            busy  <= 1'b1;
            state <= RUN;
`ifdef ENABLE_SEQ_BURST_EN
            pulses  <= '0;
            len_q   <= burst_len;
            burst_q <= mode_burst;
            // Empty burst completes without a strobe.
            if (mode_burst && (burst_len == '0)) state <= DONE;
`endif
          end
        end
        RUN: begin
          if (stop) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            busy <= 1'b1;
            if (tick) begin
              enable <= 1'b1;
`ifdef ENABLE_SEQ_BURST_EN
              if (burst_q) begin
                pulses <= pulses_inc_c;
                if (pulses_inc_c == len_q) state <= DONE;
              end
`endif
            end
          end
        end
`ifdef ENABLE_SEQ_BURST_EN
        DONE: begin
          done  <= 1'b1;
          busy  <= 1'b1;
          state <= IDLE;
        end
`endif
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_enable_sequencer.sv
// tb_enable_sequencer: randomized self-checking bench for enable_sequencer.
// Expected outputs come from a closed-form model of a run: relative edge n
// after the accepting edge E0, ratio d, burst length l and stop edge es.
// Burst scenarios are compiled only when ENABLE_SEQ_BURST_EN is defined.
module tb_enable_sequencer;

  localparam int INF = 1 << 30;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [7:0] div = 8'd0;
  logic       mode_burst = 1'b0;
  logic [7:0] burst_len = 8'd0;
  logic       enable;
  logic       busy;
  logic       done;
`ifdef USE_POWER_PINS
  wire        vccd1 = 1'b1;
  wire        vssd1 = 1'b0;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  enable_sequencer #(.DIV_W(8), .BURST_W(8)) dut (
`ifdef USE_POWER_PINS
    .vccd1      (vccd1),
    .vssd1      (vssd1),
`endif
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .stop       (stop),
    .div        (div),
`ifdef ENABLE_SEQ_BURST_EN
    .mode_burst (mode_burst),
    .burst_len  (burst_len),
`endif
    .enable     (enable),
    .busy       (busy),
    .done       (done)
  );

  // Expected {enable, busy, done} after relative edge n of a run.
  function automatic logic [2:0] exp_out(input int n, input int d, input bit bm,
                                         input int l, input int es);
    int last, dedge, es_eff;
    logic en, bs, dn;
    last   = bm ? l * (d + 1) : INF;
    dedge  = bm ? last + 1 : INF;
    es_eff = (es > last) ? INF : es;
    en = (n >= 1) && (n < es_eff) && (n <= last) && ((n % (d + 1)) == 0);
    dn = bm && (es_eff == INF) && (n == dedge);
    bs = (n < es_eff) && (n <= dedge);
    return {en, bs, dn};
  endfunction

  // One run from an idle DUT; per-edge comparison against the model.
  task automatic run_case(input string tag, input int d, input bit bm, input int l,
                          input int es, output int strobes, output int dones);
    logic [2:0] e, o;
    int horizon, last;
    last    = bm ? l * (d + 1) : INF;
    horizon = ((es <= last) ? es : last + 1) + 2;
    strobes = 0;
    dones   = 0;
    div        = 8'(d);
    mode_burst = bm;
    burst_len  = 8'(l);
    start      = 1'b1;
    stop       = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    for (int n = 0; n <= horizon; n++) begin
      if (n > 0) begin
        @(posedge clk); #1;
      end
      o = {enable, busy, done};
      e = exp_out(n, d, bm, l, es);
      tests_run++;
      if (o !== e) begin
        tests_failed++;
        $display("FAIL %s n=%0d d=%0d burst=%0d len=%0d es=%0d en/busy/done got %b want %b",
                 tag, n, d, bm, l, es, o, e);
      end
      strobes += int'(enable);
      dones   += int'(done);
      // Mid-run changes to the latched inputs must be ignored.
      div        = 8'($urandom);
      burst_len  = 8'($urandom);
      mode_burst = 1'($urandom);
      stop       = (n + 1 == es);
    end
    stop = 1'b0;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    tests_run++;
    if ({enable, busy, done} !== 3'b000) begin
      tests_failed++;
      $display("FAIL reset_state got %b want 000", {enable, busy, done});
    end
    reset_n = 1'b1;
    div = 8'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
    end
    tests_run++;
    if ({enable, busy, done} !== exp_out(4, 3, 1'b0, 0, INF)) begin
      tests_failed++;
      $display("FAIL pre_reset_strobe got %b want %b", {enable, busy, done},
               exp_out(4, 3, 1'b0, 0, INF));
    end
    #2 reset_n = 1'b0;
    #1;
    tests_run++;
    if ({enable, busy, done} !== 3'b000) begin
      tests_failed++;
      $display("FAIL async_reset got %b want 000", {enable, busy, done});
    end
    @(posedge clk); #2;
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      tests_run++;
      if ({enable, busy, done} !== 3'b000) begin
        tests_failed++;
        $display("FAIL post_reset_idle cycle=%0d got %b want 000", i, {enable, busy, done});
      end
    end
  endtask

  task automatic test_continuous();
    int s, dn;
    run_case("continuous_div3", 3, 1'b0, 0, 15, s, dn);
    tests_run++;
    if (s != 3 || dn != 0) begin
      tests_failed++;
      $display("FAIL continuous_count strobes=%0d dones=%0d want 3 and 0", s, dn);
    end
  endtask

  task automatic test_div0_stop();
    int s, dn;
    run_case("div0_stop", 0, 1'b0, 0, 10, s, dn);
    tests_run++;
    if (s != 9) begin
      tests_failed++;
      $display("FAIL div0_strobe_count got %0d want 9", s);
    end
  endtask

  task automatic test_start_stop_idle();
    div = 8'd0; start = 1'b1; stop = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      tests_run++;
      if ({enable, busy, done} !== 3'b000) begin
        tests_failed++;
        $display("FAIL start_stop_idle cycle=%0d got %b want 000", i, {enable, busy, done});
      end
    end
    start = 1'b0; stop = 1'b0;
  endtask

  task automatic test_random();
    int d, l, es, s, dn;
    bit bm;
    for (int it = 0; it < 12; it++) begin
      d = int'($urandom_range(0, 7));
      l = int'($urandom_range(0, 6));
`ifdef ENABLE_SEQ_BURST_EN
      bm = 1'($urandom_range(0, 1));
`else
      bm = 1'b0;
`endif
      if (bm) es = ($urandom_range(0, 1) == 0) ? INF : int'($urandom_range(1, l * (d + 1) + 3));
      else    es = int'($urandom_range(1, 40));
      run_case("random", d, bm, l, es, s, dn);
    end
  endtask

`ifdef ENABLE_SEQ_BURST_EN
  task automatic test_burst();
    int s, dn;
    run_case("burst_div1_len5", 1, 1'b1, 5, INF, s, dn);
    tests_run++;
    if (s != 5 || dn != 1) begin
      tests_failed++;
      $display("FAIL burst_counts strobes=%0d dones=%0d want 5 and 1", s, dn);
    end
  endtask

  task automatic test_len0();
    int s, dn;
    run_case("burst_len0", 4, 1'b1, 0, INF, s, dn);
    tests_run++;
    if (s != 0 || dn != 1) begin
      tests_failed++;
      $display("FAIL len0_counts strobes=%0d dones=%0d want 0 and 1", s, dn);
    end
  endtask

  task automatic test_stop_in_burst();
    int s, dn;
    run_case("burst_stop", 2, 1'b1, 4, 7, s, dn);
    tests_run++;
    if (s != 2 || dn != 0) begin
      tests_failed++;
      $display("FAIL burst_stop_counts strobes=%0d dones=%0d want 2 and 0", s, dn);
    end
  endtask

  // start held through done: second run accepted at E6 with new div/len.
  task automatic test_back_to_back();
    logic [2:0] e, o;
    int s2;
    s2 = 0;
    div = 8'd1; burst_len = 8'd2; mode_burst = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    div = 8'd2; burst_len = 8'd3;
    for (int n = 0; n <= 18; n++) begin
      if (n > 0) begin
        @(posedge clk); #1;
      end
      if (n == 6) start = 1'b0;
      e = (n < 6) ? exp_out(n, 1, 1'b1, 2, INF) : exp_out(n - 6, 2, 1'b1, 3, INF);
      o = {enable, busy, done};
      tests_run++;
      if (o !== e) begin
        tests_failed++;
        $display("FAIL back_to_back n=%0d en/busy/done got %b want %b", n, o, e);
      end
      if (n >= 6) s2 += int'(enable);
    end
    tests_run++;
    if (s2 != 3) begin
      tests_failed++;
      $display("FAIL back_to_back_strobes got %0d want 3", s2);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_continuous();
    test_div0_stop();
    test_start_stop_idle();
`ifdef ENABLE_SEQ_BURST_EN
    test_burst();
    test_len0();
    test_stop_in_burst();
    test_back_to_back();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
